// File: rtl/vga_pkg.sv
// vga_pkg -- shared constants and helpers for the VGA frame reader.
//   640x480 @ 800x525 total timing, 300x300 image window, memory layout
//   (image region at 0, RAM result region at RAM_BASE), pipeline control
//   struct and the window test used for both current and next counts.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

    localparam int IMG_W    = 300;
    localparam int IMG_H    = 300;
    localparam int SIN_BASE = 90000;    // first word after the image region
    localparam int RAM_BASE = 90300;    // RAM result region base

    localparam int AW = 18;
    localparam int DW = 24;

    // Control bits carried alongside the memory read latency.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic win;
    } vga_ctl_t;

    localparam vga_ctl_t CTL_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, win: 1'b0};

    function automatic logic in_window(input logic [9:0] h, input logic [9:0] v,
                                       input int x0, input int y0);
        return (int'(h) >= x0) && (int'(h) < x0 + IMG_W) &&
               (int'(v) >= y0) && (int'(v) < y0 + IMG_H);
    endfunction

endpackage

// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if -- memory port-B read bus.
//   address_b   : read address (reader -> memory)
//   read_data_b : read data {R,G,B}, READ_LATENCY cycles after the address
interface vga_frame_reader_if;
    import vga_pkg::*;

    logic [AW-1:0] address_b;
    logic [DW-1:0] read_data_b;

    modport master (output address_b, input  read_data_b);
    modport slave  (input  address_b, output read_data_b);
endinterface

// File: rtl/vga_timing.sv
// vga_timing -- 800x525 raster counters and undelayed sync/active.
//   clk, rst        : pixel clock, synchronous active-high reset
//   o_h, o_v        : current counts
//   o_h_nxt,o_v_nxt : counts of the following cycle (for registered lookahead)
//   o_hsync,o_vsync : undelayed active-low sync, o_active: undelayed active area
//   o_frame_start   : registered pulse during the h=0,v=0 cycle
module vga_timing
    import vga_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic [9:0] o_h_nxt,
    output logic [9:0] o_v_nxt,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_active,
    output logic       o_frame_start
);

    logic [9:0] r_h, r_v;
    logic       r_run;          // low for the first cycle after reset: hold at 0,0
    logic       r_frame_start;
    logic [9:0] w_h_nxt, w_v_nxt;

    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (r_run) begin
            if (r_h == 10'(H_TOTAL - 1)) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
            end else begin
                w_h_nxt = r_h + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h           <= '0;
            r_v           <= '0;
            r_run         <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_run         <= 1'b1;
            r_frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_h_nxt       = w_h_nxt;
    assign o_v_nxt       = w_v_nxt;
    assign o_hsync       = !((r_h >= 10'(H_ACTIVE + H_FP)) &&
                             (r_h <  10'(H_ACTIVE + H_FP + H_SYNC)));
    assign o_vsync       = !((r_v >= 10'(V_ACTIVE + V_FP)) &&
                             (r_v <  10'(V_ACTIVE + V_FP + V_SYNC)));
    assign o_active      = (r_h < 10'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
    assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader -- streams a 300x300 window from memory onto VGA.
//   clk, rst      : pixel clock (also memory port B), sync active-high reset
//   frame_select  : 0 = image region, 1 = RAM result region; taken at frame start
//   mem           : port-B read bus (address_b out, read_data_b in)
//   hsync, vsync  : active-low sync, delayed to line up with read data
//   vga_blank_n   : high in the 640x480 active area
//   vga_r/g/b     : pixel colour, zero outside the window
//   frame_start   : one-cycle pulse at h=0,v=0 (not delayed)
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int IMG_X0       = 170,
    parameter int IMG_Y0       = 90
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_select,
    vga_frame_reader_if.master        mem,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      vga_blank_n,
    output logic [7:0]                vga_r,
    output logic [7:0]                vga_g,
    output logic [7:0]                vga_b,
    output logic                      frame_start
);

    logic [9:0]    w_h, w_v, w_h_nxt, w_v_nxt;
    logic          w_hs, w_vs, w_act;
    logic          w_win_cur, w_win_nxt, w_sof_nxt;
    logic [AW-1:0] w_base_nxt, w_pix_nxt;
    vga_ctl_t      w_ctl;

    logic [AW-1:0] r_base, r_pix, r_addr;
    vga_ctl_t [READ_LATENCY-1:0] r_pipe;

    vga_timing u_timing (
        .clk           (clk),
        .rst           (rst),
        .o_h           (w_h),
        .o_v           (w_v),
        .o_h_nxt       (w_h_nxt),
        .o_v_nxt       (w_v_nxt),
        .o_hsync       (w_hs),
        .o_vsync       (w_vs),
        .o_active      (w_act),
        .o_frame_start (frame_start)
    );

    // address_b is a register, so it is computed from the next cycle's
    // counts; that keeps it in step with the undelayed in_window.
    assign w_win_cur  = in_window(w_h, w_v, IMG_X0, IMG_Y0);
    assign w_win_nxt  = in_window(w_h_nxt, w_v_nxt, IMG_X0, IMG_Y0);
    assign w_sof_nxt  = (w_h_nxt == '0) && (w_v_nxt == '0);
    assign w_base_nxt = w_sof_nxt ? (frame_select ? AW'(RAM_BASE) : '0) : r_base;
    assign w_pix_nxt  = w_sof_nxt ? '0 : (w_win_cur ? r_pix + AW'(1) : r_pix);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base <= '0;
            r_pix  <= '0;
            r_addr <= '0;
        end else begin
            r_base <= w_base_nxt;
            r_pix  <= w_pix_nxt;
            r_addr <= w_win_nxt ? w_base_nxt + w_pix_nxt : w_base_nxt;
        end
    end

    assign mem.address_b = r_addr;

    // Sync/active/window travel READ_LATENCY stages to meet the read data.
    assign w_ctl = '{hs: w_hs, vs: w_vs, act: w_act, win: w_win_cur};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LATENCY; i++) r_pipe[i] <= CTL_IDLE;
        end else begin
            r_pipe[0] <= w_ctl;
            for (int i = 1; i < READ_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign hsync       = r_pipe[READ_LATENCY-1].hs;
    assign vsync       = r_pipe[READ_LATENCY-1].vs;
    assign vga_blank_n = r_pipe[READ_LATENCY-1].act;
    assign {vga_r, vga_g, vga_b} = r_pipe[READ_LATENCY-1].win ? mem.read_data_b : '0;

endmodule

// File: doc/vga_frame_reader.md
VGA_FRAME_READER -- requirements
Module: vga_frame_reader

Interface
REQ-001 Parameter READ_LATENCY, default 2: cycles from address_b to valid read_data_b (registered address and registered output at the memory port).
REQ-002 Parameter IMG_X0, default 170: first displayed image column.
REQ-003 Parameter IMG_Y0, default 90: first displayed image row.
REQ-004 Port: clk  in  1  pixel clock, 25 MHz; the same clock drives memory port B.
REQ-005 Port: rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006 Port: frame_select  in  1  0 = image region (base 0), 1 = RAM result region (base 90300).
REQ-007 Port: address_b  out  18  memory port-B read address.
REQ-008 Port: read_data_b  in  24  memory port-B read data; [23:16]=R, [15:8]=G, [7:0]=B.
REQ-009 Port: hsync, vsync  out  1 each  active-low sync pulses.
REQ-010 Port: vga_blank_n  out  1  high in the 640x480 active area.
REQ-011 Port: vga_r, vga_g, vga_b  out  8 each  pixel colour.
REQ-012 Port: frame_start  out  1  one-cycle pulse when h=0, v=0 (undelayed).

Function
REQ-013 h_count SHALL count 0..799 and wrap to 0; v_count SHALL increment on each h wrap and wrap 524->0.
REQ-014 Timing (undelayed): active h<640 and v<480; hsync low for h 656..751; vsync low for v 490..491.
REQ-015 in_window SHALL be true for h in [IMG_X0, IMG_X0+299] and v in [IMG_Y0, IMG_Y0+299].
REQ-016 base SHALL be latched from frame_select only when h=0, v=0; a mid-frame change SHALL take effect on the next frame.
REQ-017 pixel_addr SHALL clear to 0 at h=0, v=0 and increment by 1 in every in_window cycle; no multiplier.
REQ-018 address_b SHALL equal base+pixel_addr in in_window cycles and base otherwise.
REQ-019 Last window address SHALL be base+89999 (89999 or 180299); the result SHALL fit 18 bits.
REQ-020 hsync, vsync, active and in_window SHALL be delayed READ_LATENCY cycles through a shift register before driving the outputs.
REQ-021 RGB SHALL equal read_data_b when delayed in_window is set; 0 in the active area outside the window and during blanking.
REQ-022 All outputs SHALL be registered, except the read_data_b-to-RGB select, which is combinational after the delay stage.

Reset
REQ-023 While rst is high: h_count, v_count, pixel_addr, base and address_b = 0; hsync = vsync = 1; vga_blank_n = 0; RGB = 0; frame_start = 0; delay pipeline cleared to the inactive state.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately.
REQ-025 After reset deasserts, the first cycle SHALL be h=0, v=0 with frame_start = 1.

Structure
REQ-026 Package vga_pkg SHALL hold the timing constants (640/16/96/48, 480/10/2/33), IMG_W = IMG_H = 300, SIN_BASE = 90000 and RAM_BASE = 90300.
REQ-027 Sub-module vga_timing SHALL contain the counters and undelayed sync/active generation; vga_frame_reader SHALL add the addressing and latency alignment.

Verification
REQ-028 Reset: rst high for 3 cycles mid-line -> hsync = vsync = 1, RGB = 0, address_b = 0; first cycle after release frame_start = 1.
REQ-029 Line/frame timing: hsync low for 96 cycles, first low at cycle 658 of each 800-cycle line (READ_LATENCY=2); vsync low on lines 490-491 plus latency; 420000 cycles between frame_start pulses.
REQ-030 Addressing, frame_select=0: (v=90,h=170) -> 0; (90,469) -> 299; (91,170) -> 300; (389,469) -> 89999.
REQ-031 Latency: memory model with READ_LATENCY=2 returning {6'b0, address} -> first window pixel RGB = 0x000000 on the cycle the delayed in_window rises; pixel 300 -> 0x00012C; window border pixels = 0.
REQ-032 Frame switch: frame_select 0->1 at v=200 -> the rest of the frame stays in 0..89999; the next frame spans 90300..180299.
REQ-033 Reset mid-frame at v=300 -> outputs take reset values the next cycle; restart at frame_start with pixel_addr = 0 and base set from the current frame_select.
